write_cmd_arbiter: RTL and testbench

Round-robin arbiter that merges NUM_SRC AXI-Stream-style write-command streams (ram_controller src_write_cmd format, 96-bit tdata) into one output stream feeding the shared HPS-side write path. Packets are atomic: once a source is granted, it keeps the output until its tlast beat is accepted. The output is registered through a 2-entry skid buffer. Per-source packet counters give software/debug visibility. Sits in the FPGA fabric between the ram_controller instances and the single downstream write-command consumer, clocked on system_clk_100.

---
 rtl/write_cmd_arbiter.sv | 178 +++++++++++++++++
 tb/tb_write_cmd_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_cmd_arbiter.sv
// Round-robin arbiter merging NUM_SRC write-command streams into one output.
// Packets are atomic per grant; the output is registered through a 2-entry buffer.
module write_cmd_arbiter #(
    parameter  int NUM_SRC    = 2,
    parameter  int DATA_WIDTH = 96,
    parameter  int CNT_WIDTH  = 16,
    localparam int IDW        = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_SRC-1:0]            s_tvalid,
    output logic [NUM_SRC-1:0]            s_tready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]            s_tlast,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tlast,
    output logic [IDW-1:0]                grant_id,
    output logic                          busy,
    input  logic                          clr_counts,
    output logic [NUM_SRC*CNT_WIDTH-1:0]  pkt_count
);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [IDW-1:0] r_grant_id, w_grant_id_nxt;
    logic [IDW-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic           r_busy, w_busy_nxt;

    logic                  w_req_found;
    logic [IDW-1:0]        w_req_idx;
    logic                  w_beat_valid;
    logic                  w_beat_last;
    logic [DATA_WIDTH-1:0] w_beat_data;
    logic                  w_room;
    logic                  w_accept;
    logic                  w_pkt_done;
    logic                  w_pop;

    logic [DATA_WIDTH:0]   r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_buf_count;
    logic [CNT_WIDTH-1:0]  r_cnt [NUM_SRC];

    // Search for the first requester starting at r_rr_ptr, wrapping past NUM_SRC-1.
    always_comb begin
        int idx;
        w_req_found = 1'b0;
        w_req_idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!w_req_found && s_tvalid[idx]) begin
                w_req_found = 1'b1;
                w_req_idx   = IDW'(idx);
            end
        end
    end

    always_comb begin
        w_beat_valid = 1'b0;
        w_beat_last  = 1'b0;
        w_beat_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant_id == IDW'(i)) begin
                w_beat_valid = s_tvalid[i];
                w_beat_last  = s_tlast[i];
                w_beat_data  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_room     = (r_buf_count != 2'd2);
    assign w_accept   = (r_state == ST_GRANT) && w_beat_valid && w_room;
    assign w_pkt_done = w_accept && w_beat_last;
    assign w_pop      = (r_buf_count != 2'd0) && m_tready;

    always_comb begin
        s_tready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            s_tready[i] = (r_state == ST_GRANT) && (r_grant_id == IDW'(i)) && w_room;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_id_nxt = r_grant_id;
        w_busy_nxt     = r_busy;
        w_rr_ptr_nxt   = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_req_found) begin
                    w_state_nxt    = ST_GRANT;
                    w_grant_id_nxt = w_req_idx;
                    w_busy_nxt     = 1'b1;
                end
            end
            ST_GRANT: begin
                if (w_pkt_done) begin
                    w_state_nxt  = ST_IDLE;
                    w_busy_nxt   = 1'b0;
                    w_rr_ptr_nxt = (r_grant_id == IDW'(NUM_SRC-1)) ? '0 : r_grant_id + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_rr_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_busy     <= w_busy_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
        end
    end

    // NOTE: the two buffer entries are reset because the head entry drives m_tdata/m_tlast, which must read 0 out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem[0]    <= '0;
            r_mem[1]    <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_buf_count <= 2'd0;
        end else begin
            if (w_accept) begin
                r_mem[r_wr_ptr] <= {w_beat_last, w_beat_data};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            case ({w_accept, w_pop})
                2'b10:   r_buf_count <= r_buf_count + 2'd1;
                2'b01:   r_buf_count <= r_buf_count - 2'd1;
                default: r_buf_count <= r_buf_count;
            endcase
        end
    end

    assign m_tvalid = (r_buf_count != 2'd0);
    assign m_tdata  = r_mem[r_rd_ptr][DATA_WIDTH-1:0];
    assign m_tlast  = r_mem[r_rd_ptr][DATA_WIDTH];
    assign grant_id = r_grant_id;
    assign busy     = r_busy;

    // Clear takes priority over a coincident increment; counters stick at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SRC; i++) r_cnt[i] <= '0;
        end else if (clr_counts) begin
            for (int i = 0; i < NUM_SRC; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_pkt_done && (r_grant_id == IDW'(i)) && (r_cnt[i] != '1)) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cnt
        assign pkt_count[gi*CNT_WIDTH +: CNT_WIDTH] = r_cnt[gi];
    end

endmodule

// File: tb/tb_write_cmd_arbiter.sv
// Randomized scoreboard bench for write_cmd_arbiter: a packet-level round-robin
// model predicts beat order, grant order and packet counts.
module tb_write_cmd_arbiter;

    localparam int N   = 3;
    localparam int DW  = 96;
    localparam int CW  = 4;
    localparam int IDW = $clog2(N);
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      s_tvalid;
    logic [N-1:0]      s_tready;
    logic [N*DW-1:0]   s_tdata;
    logic [N-1:0]      s_tlast;
    logic              m_tvalid;
    logic              m_tready;
    logic [DW-1:0]     m_tdata;
    logic              m_tlast;
    logic [IDW-1:0]    grant_id;
    logic              busy;
    logic              clr_counts;
    logic [N*CW-1:0]   pkt_count;

    write_cmd_arbiter #(
        .NUM_SRC    (N),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .grant_id   (grant_id),
        .busy       (busy),
        .clr_counts (clr_counts),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Source drivers and reference model state
    beat_t src_q [N][$];
    bit    mid [N];
    beat_t mdl_q [N][$];
    int    mdl_len [N][$];
    int    mdl_rr = 0;
    int    mdl_cnt [N];
    int    pkt_seq = 0;
    bit    clr_on_last = 1'b0;
    bit    mon_en = 1'b0;

    // Scoreboard
    beat_t exp_q [$];
    int    exp_grant [$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_packet(input int src, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data         = {$urandom, $urandom, $urandom};
            b.data[95:88]  = 8'(src);
            b.data[87:80]  = 8'(pkt_seq);
            b.data[79:72]  = 8'(k);
            b.last         = (k == len - 1);
            src_q[src].push_back(b);
            mdl_q[src].push_back(b);
        end
        mdl_len[src].push_back(len);
        pkt_seq++;
    endtask

    // Packet-level round robin: every source with a pending packet is requesting.
    task automatic model_resolve();
        bit any;
        int s;
        int len;
        do begin
            any = 1'b0;
            for (int k = 0; k < N && !any; k++) begin
                s = (mdl_rr + k) % N;
                if (mdl_len[s].size() > 0) any = 1'b1;
            end
            if (any) begin
                len = mdl_len[s].pop_front();
                exp_grant.push_back(s);
                for (int k = 0; k < len; k++) exp_q.push_back(mdl_q[s].pop_front());
                if (mdl_cnt[s] < CNT_MAX) mdl_cnt[s]++;
                mdl_rr = (s + 1) % N;
            end
        end while (any);
    endtask

    function automatic bit all_empty();
        bit e;
        e = (exp_q.size() == 0) && (exp_grant.size() == 0);
        for (int i = 0; i < N; i++) e = e && (src_q[i].size() == 0);
        return e;
    endfunction

    task automatic drive_inputs(input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0 && (!mid[i] || !gaps || $urandom_range(0, 3) != 0)) begin
                s_tvalid[i]          = 1'b1;
                s_tdata[i*DW +: DW]  = src_q[i][0].data;
                s_tlast[i]           = src_q[i][0].last;
            end else begin
                s_tvalid[i]          = 1'b0;
                s_tdata[i*DW +: DW]  = {$urandom, $urandom, $urandom};
                s_tlast[i]           = 1'($urandom);
            end
        end
    endtask

    // rmode: 0 = m_tready high, 1 = random, 2 = m_tready low.
    // stop_fires: >0 stop after that many accepted beats, 0 stop when drained, <0 fixed length.
    task automatic run(input int rmode, input bit gaps, input int max_cyc,
                       input int stop_fires, output int fired);
        bit           done;
        logic [N-1:0] fire;
        beat_t        b;
        fired = 0;
        done  = 1'b0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            drive_inputs(gaps);
            m_tready = (rmode == 0) ? 1'b1 : (rmode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
            @(negedge clk);
            fire = s_tvalid & s_tready;
            if (clr_on_last && |(fire & s_tlast)) begin
                clr_counts  = 1'b1;
                clr_on_last = 1'b0;
            end
            @(posedge clk);
            #1;
            clr_counts = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (fire[i]) begin
                    b      = src_q[i].pop_front();
                    mid[i] = !b.last;
                    fired++;
                end
            end
            if (stop_fires > 0)       done = (fired >= stop_fires);
            else if (stop_fires == 0) done = all_empty();
        end
        if (stop_fires >= 0) check("run_completed_within_budget", 96'(done), 96'(1));
    endtask

    task automatic check_counts(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s pkt_count[%0d]", tag, i), 96'(pkt_count[i*CW +: CW]), 96'(mdl_cnt[i]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " m_tvalid"}, 96'(m_tvalid), 96'(0));
        check({tag, " m_tdata"},  m_tdata,       96'(0));
        check({tag, " m_tlast"},  96'(m_tlast),  96'(0));
        check({tag, " s_tready"}, 96'(s_tready), 96'(0));
        check({tag, " busy"},     96'(busy),     96'(0));
        check({tag, " grant_id"}, 96'(grant_id), 96'(0));
        check({tag, " pkt_count"}, 96'(pkt_count), 96'(0));
    endtask

    // Monitor: beat order, grant order, output stability and ready exclusivity.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic          prev_busy = 1'b0;
    beat_t         mon_exp;

    always @(negedge clk) begin
        if (reset_n && mon_en) begin
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output_beat", 96'(1), 96'(0));
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("m_tdata", m_tdata, mon_exp.data);
                    check("m_tlast", 96'(m_tlast), 96'(mon_exp.last));
                end
            end
            if (prev_stall) begin
                check("stall m_tvalid held", 96'(m_tvalid), 96'(1));
                check("stall m_tdata held", m_tdata, prev_data);
                check("stall m_tlast held", 96'(m_tlast), 96'(prev_last));
            end
            if (busy && !prev_busy) begin
                if (exp_grant.size() == 0) check("unexpected_grant", 96'(1), 96'(0));
                else check("grant_id", 96'(grant_id), 96'(exp_grant.pop_front()));
            end
            if (s_tready != '0) check("s_tready only to grant", 96'(s_tready), 96'(1) << grant_id);
            if (!busy) check("s_tready low while idle", 96'(s_tready), 96'(0));
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
            prev_busy  = busy;
        end else begin
            prev_stall = 1'b0;
            prev_busy  = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fired;
        for (int i = 0; i < N; i++) begin
            mid[i]     = 1'b0;
            mdl_cnt[i] = 0;
        end

        // Reset held with random inputs
        reset_n    = 1'b0;
        for (int c = 0; c < 4; c++) begin
            s_tvalid   = N'($urandom);
            s_tdata    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            s_tlast    = N'($urandom);
            m_tready   = 1'($urandom);
            clr_counts = 1'($urandom);
            @(negedge clk);
            check_reset_outputs("reset");
        end
        s_tvalid   = '0;
        s_tlast    = '0;
        s_tdata    = '0;
        m_tready   = 1'b0;
        clr_counts = 1'b0;
        reset_n    = 1'b1;
        @(negedge clk);
        check("idle after release busy", 96'(busy), 96'(0));
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Fairness: 1-beat packets from src0 and src1 alternate
        for (int p = 0; p < 4; p++) begin
            add_packet(0, 1);
            add_packet(1, 1);
        end
        model_resolve();
        run(0, 1'b0, 200, 0, fired);
        check_counts("fairness");

        // Atomicity: 4-beat packet on src0 while src1 requests
        add_packet(0, 4);
        add_packet(1, 2);
        model_resolve();
        run(1, 1'b1, 300, 0, fired);
        check_counts("atomicity");

        // Backpressure: 5-beat packet with m_tready low
        add_packet(2, 5);
        model_resolve();
        run(2, 1'b0, 10, -1, fired);
        check("backpressure accepted beats", 96'(fired), 96'(2));
        check("backpressure s_tready", 96'(s_tready), 96'(0));
        check("backpressure m_tvalid", 96'(m_tvalid), 96'(1));
        run(0, 1'b0, 100, 0, fired);
        check_counts("backpressure");

        // Random traffic on all sources
        for (int p = 0; p < 18; p++) add_packet($urandom_range(0, N-1), $urandom_range(1, 4));
        model_resolve();
        run(1, 1'b1, 2000, 0, fired);
        check_counts("random");

        // Saturation on src1
        for (int p = 0; p < 20; p++) add_packet(1, $urandom_range(1, 2));
        model_resolve();
        run(1, 1'b0, 2000, 0, fired);
        check_counts("saturation");

        // Clear coinciding with a tlast acceptance: clear wins
        clr_on_last = 1'b1;
        add_packet(0, 2);
        model_resolve();
        run(0, 1'b0, 100, 0, fired);
        for (int i = 0; i < N; i++) mdl_cnt[i] = 0;
        check_counts("clear");
        add_packet(2, 1);
        model_resolve();
        run(0, 1'b0, 100, 0, fired);
        check_counts("after clear");

        // Wrap: last grant src2, then src0 and src1 request -> src0 first
        add_packet(1, 2);
        add_packet(0, 3);
        model_resolve();
        run(1, 1'b0, 200, 0, fired);
        check_counts("wrap");

        // Reset after 2 beats of a 4-beat packet
        add_packet(1, 4);
        model_resolve();
        run(0, 1'b0, 50, 2, fired);
        check("pre-reset m_tvalid", 96'(m_tvalid), 96'(1));
        check("pre-reset busy", 96'(busy), 96'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid-packet reset");
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            mdl_q[i].delete();
            mdl_len[i].delete();
            mid[i]     = 1'b0;
            mdl_cnt[i] = 0;
        end
        exp_q.delete();
        exp_grant.delete();
        mdl_rr   = 0;
        s_tvalid = '0;
        s_tlast  = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset hold");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Recovery after reset: src1 then src2 from rr_ptr 0
        add_packet(2, 1);
        add_packet(1, 2);
        model_resolve();
        run(1, 1'b1, 200, 0, fired);
        check_counts("post reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
